// File: rtl/uart_rx_bcd.sv
// Receiver for the two-digit BCD link: 7O1 UART frames are decoded by mid-bit sampling.
// The "<d1><d0><CR>" triplets are then reassembled into two BCD digits with a one-cycle strobe.
module uart_rx_bcd #(
  parameter int BIT_CYCLES  = 279,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_in,
  output logic [6:0] bcd1,
  output logic [6:0] bcd0,
  output logic       valid,
  output logic [6:0] char_out,
  output logic       char_valid,
  output logic       parity_err,
  output logic       frame_err,
  output logic       seq_err,
  output logic [2:0] dbg_state
);

  localparam int CNT_W = $clog2(BIT_CYCLES);
  localparam logic [CNT_W-1:0] HALF_M1   = CNT_W'(BIT_CYCLES / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1   = CNT_W'(BIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SYNC_WAIT = CNT_W'(SYNC_STAGES);

  typedef enum logic [2:0] {
    S_WAIT_IDLE = 3'd0,
    S_IDLE      = 3'd1,
    S_START     = 3'd2,
    S_DATA      = 3'd3,
    S_PARITY    = 3'd4,
    S_STOP      = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_bit_idx;
  logic [6:0]             r_shift;
  logic                   r_par;
  logic [1:0]             r_slot;
  logic [3:0]             r_d1;
  logic [3:0]             r_d0;
  logic                   w_rx;
  logic                   w_mid;
  logic                   w_full;
  logic                   w_shift;
  logic                   w_par_cap;
  logic                   w_char_ok;
  logic                   w_perr;
  logic                   w_ferr;
  logic                   w_cnt_clr;
  logic                   w_par_ok;
  logic                   w_is_digit;

  assign w_rx       = r_sync[SYNC_STAGES-1];
  assign w_mid      = (r_cnt == HALF_M1);
  assign w_full     = (r_cnt == FULL_M1);
  assign w_par_ok   = ^{r_shift, r_par};
  assign w_cnt_clr  = (w_next_state != r_state) || w_shift;
  assign w_is_digit = (char_out >= 7'h30) && (char_out <= 7'h39);
  assign dbg_state  = r_state;

  always_ff @(posedge clk) begin
    if (!rst) r_sync <= '1;
    else      r_sync <= {r_sync[SYNC_STAGES-2:0], rx_in};
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_WAIT_IDLE;
    else      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_shift      = 1'b0;
    w_par_cap    = 1'b0;
    w_char_ok    = 1'b0;
    w_perr       = 1'b0;
    w_ferr       = 1'b0;
    case (r_state)
      // The synchronizer resets to 1, so its contents are ignored until they
      // have been flushed with real line samples.
      S_WAIT_IDLE: if (w_rx && (r_cnt >= SYNC_WAIT)) w_next_state = S_IDLE;
      S_IDLE:      if (!w_rx) w_next_state = S_START;
      S_START:     if (w_mid) w_next_state = w_rx ? S_IDLE : S_DATA;
      S_DATA: begin
        if (w_full) begin
          w_shift = 1'b1;
          if (r_bit_idx == 3'd6) w_next_state = S_PARITY;
        end
      end
      S_PARITY: begin
        if (w_full) begin
          w_par_cap    = 1'b1;
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_full) begin
          if (!w_rx) begin
            w_ferr       = 1'b1;
            w_next_state = S_WAIT_IDLE;
          end else begin
            w_perr       = !w_par_ok;
            w_char_ok    = w_par_ok;
            w_next_state = S_IDLE;
          end
        end
      end
      default: w_next_state = S_WAIT_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_par      <= 1'b0;
      char_out   <= '0;
      char_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
      char_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      if (r_state == S_START) begin
        r_bit_idx <= '0;
      end else if (w_shift) begin
        r_shift   <= {w_rx, r_shift[6:1]};
        r_bit_idx <= r_bit_idx + 3'd1;
      end
      if (w_par_cap) r_par <= w_rx;
      if (w_char_ok) begin
        char_out   <= r_shift;
        char_valid <= 1'b1;
      end
      if (w_perr) parity_err <= 1'b1;
      if (w_ferr) frame_err  <= 1'b1;
    end
  end

  // Triplet assembler: any unexpected good character restarts at slot 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_slot  <= '0;
      r_d1    <= '0;
      r_d0    <= '0;
      bcd1    <= '0;
      bcd0    <= '0;
      valid   <= 1'b0;
      seq_err <= 1'b0;
    end else begin
      valid   <= 1'b0;
      seq_err <= 1'b0;
      if (char_valid) begin
        case (r_slot)
          2'd0: begin
            if (w_is_digit) begin
              r_d1   <= char_out[3:0];
              r_slot <= 2'd1;
            end else begin
              seq_err <= 1'b1;
              r_slot  <= 2'd0;
            end
          end
          2'd1: begin
            if (w_is_digit) begin
              r_d0   <= char_out[3:0];
              r_slot <= 2'd2;
            end else begin
              seq_err <= 1'b1;
              r_slot  <= 2'd0;
            end
          end
          default: begin
            if (char_out == 7'h0D) begin
              bcd1  <= {3'b000, r_d1};
              bcd0  <= {3'b000, r_d0};
              valid <= 1'b1;
            end else begin
              seq_err <= 1'b1;
            end
            r_slot <= 2'd0;
          end
        endcase
      end else if (parity_err || frame_err) begin
        r_slot <= 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_bcd.sv
// Directed bench for uart_rx_bcd: serial frames are driven at several bit periods.
// Pulse counts, received characters and decoded digits are checked against hand-computed values.
module tb_uart_rx_bcd;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx_in = 1'b1;
  logic [6:0] bcd1, bcd0, char_out;
  logic       valid, char_valid, parity_err, frame_err, seq_err;
  logic [2:0] dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int n_cv = 0, n_valid = 0, n_perr = 0, n_ferr = 0, n_seq = 0, n_overlap = 0;
  int b_cv, b_valid, b_perr, b_ferr, b_seq;
  int rd_idx = 0;
  logic [6:0] got_q[$];
  logic [6:0] exp_q[$];

  uart_rx_bcd #(.BIT_CYCLES(279), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .bcd1       (bcd1),
    .bcd0       (bcd0),
    .valid      (valid),
    .char_out   (char_out),
    .char_valid (char_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .seq_err    (seq_err),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the falling edge away from DUT updates.
  always @(negedge clk) begin
    if (char_valid) begin
      n_cv++;
      got_q.push_back(char_out);
    end
    if (valid)      n_valid++;
    if (parity_err) n_perr++;
    if (frame_err)  n_ferr++;
    if (seq_err)    n_seq++;
    if ((int'(char_valid) + int'(parity_err) + int'(frame_err)) > 1 ||
        (valid && (parity_err || frame_err || seq_err)))
      n_overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_char(input logic [6:0] c, input int per, input bit bad_par, input bit bad_stop);
    logic p;
    p = ~^c;
    if (bad_par) p = ~p;
    rx_in = 1'b0;
    wait_clks(per);
    for (int i = 0; i < 7; i++) begin
      rx_in = c[i];
      wait_clks(per);
    end
    rx_in = p;
    wait_clks(per);
    rx_in = !bad_stop;
    wait_clks(per);
  endtask

  task automatic send_good(input logic [6:0] c, input int per);
    exp_q.push_back(c);
    send_char(c, per, 1'b0, 1'b0);
  endtask

  task automatic snap();
    b_cv = n_cv; b_valid = n_valid; b_perr = n_perr; b_ferr = n_ferr; b_seq = n_seq;
  endtask

  task automatic check_deltas(input string tag, input int cv, input int vl, input int pe,
                              input int fe, input int se);
    check({tag, "_char_valid_cnt"}, n_cv - b_cv, cv);
    check({tag, "_valid_cnt"},      n_valid - b_valid, vl);
    check({tag, "_parity_err_cnt"}, n_perr - b_perr, pe);
    check({tag, "_frame_err_cnt"},  n_ferr - b_ferr, fe);
    check({tag, "_seq_err_cnt"},    n_seq - b_seq, se);
  endtask

  task automatic check_chars(input string tag);
    check({tag, "_char_total"}, got_q.size(), exp_q.size());
    while (rd_idx < exp_q.size()) begin
      check({tag, "_char"}, (rd_idx < got_q.size()) ? got_q[rd_idx] : 7'h7F, exp_q[rd_idx]);
      rd_idx++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_bcd1"}, bcd1, 0);
    check({tag, "_bcd0"}, bcd0, 0);
    check({tag, "_char_out"}, char_out, 0);
    check({tag, "_pulses"}, {valid, char_valid, parity_err, frame_err, seq_err}, 0);
    check({tag, "_state"}, dbg_state, 3'd0);
  endtask

  initial begin
    // Reset with idle line
    rst = 1'b0;
    wait_clks(4);
    check_outputs_zero("reset");
    rst = 1'b1;
    wait_clks(10);
    check("reset_to_idle", dbg_state, 3'd1);

    // T1: '4','2',CR back-to-back
    snap();
    send_good(7'h34, 279); send_good(7'h32, 279); send_good(7'h0D, 279);
    wait_clks(20);
    check_deltas("t1", 3, 1, 0, 0, 0);
    check_chars("t1");
    check("t1_bcd1", bcd1, 4);
    check("t1_bcd0", bcd0, 2);

    // T2: '4', '2' with bad parity, CR, then '1','9',CR
    snap();
    send_good(7'h34, 279);
    send_char(7'h32, 279, 1'b1, 1'b0);
    send_good(7'h0D, 279);
    wait_clks(20);
    check_deltas("t2a", 2, 0, 1, 0, 1);
    check("t2a_bcd1_held", bcd1, 4);
    check("t2a_bcd0_held", bcd0, 2);
    snap();
    send_good(7'h31, 279); send_good(7'h39, 279); send_good(7'h0D, 279);
    wait_clks(20);
    check_deltas("t2b", 3, 1, 0, 0, 0);
    check_chars("t2");
    check("t2_bcd1", bcd1, 1);
    check("t2_bcd0", bcd0, 9);

    // T3: '5' with stop bit low, line low 1000 clk, then '0','3',CR
    snap();
    send_char(7'h35, 279, 1'b0, 1'b1);
    wait_clks(1000);
    check("t3_wait_idle", dbg_state, 3'd0);
    rx_in = 1'b1;
    wait_clks(50);
    check_deltas("t3a", 0, 0, 0, 1, 0);
    snap();
    send_good(7'h30, 279); send_good(7'h33, 279); send_good(7'h0D, 279);
    wait_clks(20);
    check_deltas("t3b", 3, 1, 0, 0, 0);
    check_chars("t3");
    check("t3_bcd1", bcd1, 0);
    check("t3_bcd0", bcd0, 3);

    // T4: 100-clk glitch while idle
    snap();
    rx_in = 1'b0;
    wait_clks(100);
    rx_in = 1'b1;
    wait_clks(400);
    check_deltas("t4", 0, 0, 0, 0, 0);
    check("t4_state_idle", dbg_state, 3'd1);

    // T6: remote bit period 274 then 284
    snap();
    send_good(7'h38, 274); send_good(7'h36, 274); send_good(7'h0D, 274);
    wait_clks(20);
    check_deltas("t6a", 3, 1, 0, 0, 0);
    check("t6a_bcd1", bcd1, 8);
    check("t6a_bcd0", bcd0, 6);
    snap();
    send_good(7'h39, 284); send_good(7'h37, 284); send_good(7'h0D, 284);
    wait_clks(20);
    check_deltas("t6b", 3, 1, 0, 0, 0);
    check_chars("t6");
    check("t6b_bcd1", bcd1, 9);
    check("t6b_bcd0", bcd0, 7);

    // T5: reset mid-frame with line low, release while low
    snap();
    rx_in = 1'b0;
    wait_clks(400);
    rst = 1'b0;
    wait_clks(2);
    check_outputs_zero("t5_rst");
    rst = 1'b1;
    wait_clks(600);
    check_deltas("t5_low", 0, 0, 0, 0, 0);
    check("t5_still_wait", dbg_state, 3'd0);
    rx_in = 1'b1;
    wait_clks(50);
    check("t5_idle", dbg_state, 3'd1);
    snap();
    send_good(7'h32, 279); send_good(7'h37, 279); send_good(7'h0D, 279);
    wait_clks(20);
    check_deltas("t5", 3, 1, 0, 0, 0);
    check_chars("t5");
    check("t5_bcd1", bcd1, 2);
    check("t5_bcd0", bcd0, 7);

    // T7: digit in slot 2 is dropped, CR in slot 0 resyncs, then '5','7',CR
    snap();
    send_good(7'h31, 279); send_good(7'h32, 279); send_good(7'h33, 279);
    send_good(7'h0D, 279);
    send_good(7'h35, 279); send_good(7'h37, 279); send_good(7'h0D, 279);
    wait_clks(20);
    check_deltas("t7", 7, 1, 0, 0, 2);
    check_chars("t7");
    check("t7_bcd1", bcd1, 5);
    check("t7_bcd0", bcd0, 7);

    check("pulse_overlap", n_overlap, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
